io_debounce_bank: RTL

Multi-channel input debouncer for the board's dry-contact and SCR-pulse inputs. Each channel is synchronised, qualified against separate assert/deassert run-length thresholds, and presented as a filtered level plus single-cycle rise and fall strobes. Optional per-channel chatter statistics flag noisy contacts. The block sits between the input pins and the control logic, replacing per-pin single-channel filters.

---
 rtl/io_debounce_pkg.sv | 26 ++
 rtl/io_debounce_ch.sv | 97 +++++++++
 rtl/io_debounce_bank.sv | 54 +++++
 3 files changed

// File: rtl/io_debounce_pkg.sv
// Shared widths, threshold limits and helpers for the io_debounce_bank input filter.
// Chatter statistics are built only when IO_DEBOUNCE_CHATTER_EN is defined.
package io_debounce_pkg;

   localparam int CNT_W    = 10;
   localparam int CHAT_W   = 8;
   localparam int TH_MIN   = 1;
   localparam int TH_MAX   = 1023;
   localparam int N_CH_MIN = 1;
   localparam int N_CH_MAX = 32;

   typedef struct packed {
      logic lvl;
      logic rise;
      logic fall;
      logic chatter;
   } ch_out_t;

   // The run length being qualified depends on which way the level would move.
   function automatic logic [CNT_W-1:0] sel_th(input logic                lvl,
                                               input logic [CNT_W-1:0]  on_th,
                                               input logic [CNT_W-1:0]  off_th);
      return lvl ? off_th : on_th;
   endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// One debounce channel: two-flop synchroniser, run-length qualifier, edge strobes,
// and (with IO_DEBOUNCE_CHATTER_EN) a saturating aborted-run counter with sticky flag.
module io_debounce_ch
   import io_debounce_pkg::*;
#(
   parameter logic [CNT_W-1:0]  ON_TH    = 10'd10,
   parameter logic [CNT_W-1:0]  OFF_TH   = 10'd10,
   parameter logic              RST_LVL  = 1'b0,
   parameter logic [CHAT_W-1:0] CHAT_LIM = 8'd16
) (
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_in,
   input  logic    i_chatter_clr,
   output ch_out_t o_ch
);

   logic             r_s1;
   logic             r_s2;
   logic             r_lvl;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;

   logic [CNT_W-1:0] w_th;
   logic             w_diff;
   logic             w_last;
   logic             w_abort;
   logic             w_chatter;

   assign w_th    = sel_th(r_lvl, ON_TH, OFF_TH);
   assign w_diff  = (r_s2 != r_lvl);
   assign w_last  = (r_cnt >= (w_th - CNT_W'(1)));
   assign w_abort = !w_diff && (r_cnt != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= RST_LVL;
         r_s2   <= RST_LVL;
         r_lvl  <= RST_LVL;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_s1   <= i_in;
         r_s2   <= r_s1;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_last) begin
            r_lvl  <= r_s2;
            r_cnt  <= '0;
            r_rise <= r_s2;
            r_fall <= !r_s2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

`ifdef IO_DEBOUNCE_CHATTER_EN
   logic [CHAT_W-1:0] r_chat_cnt;
   logic              r_chatter;
   logic [CHAT_W-1:0] w_chat_inc;

   assign w_chat_inc = (r_chat_cnt == '1) ? r_chat_cnt : r_chat_cnt + CHAT_W'(1);

   // Clear has priority over an abort landing in the same cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_chat_cnt <= '0;
         r_chatter  <= 1'b0;
      end else if (i_chatter_clr) begin
         r_chat_cnt <= '0;
         r_chatter  <= 1'b0;
      end else if (w_abort) begin
         r_chat_cnt <= w_chat_inc;
         if (w_chat_inc >= CHAT_LIM) begin
            r_chatter <= 1'b1;
         end
      end
   end

   assign w_chatter = r_chatter;
`else
   logic w_unused_chat;
   assign w_unused_chat = w_abort ^ i_chatter_clr ^ (|CHAT_LIM);
   assign w_chatter     = 1'b0;
`endif

   assign o_ch.lvl     = r_lvl;
   assign o_ch.rise    = r_rise;
   assign o_ch.fall    = r_fall;
   assign o_ch.chatter = w_chatter;

endmodule

// File: rtl/io_debounce_bank.sv
// N_CH-channel input debouncer bank with shared chatter clear.
// Optional chatter statistics: define IO_DEBOUNCE_CHATTER_EN.
module io_debounce_bank
   import io_debounce_pkg::*;
#(
   parameter int                N_CH     = 8,
   parameter logic [CNT_W-1:0]  ON_TH    = 10'd10,
   parameter logic [CNT_W-1:0]  OFF_TH   = 10'd10,
   parameter logic              RST_LVL  = 1'b0,
   parameter logic [CHAT_W-1:0] CHAT_LIM = 8'd16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] in_i,
   output logic [N_CH-1:0] lvl_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o,
   output logic [N_CH-1:0] chatter_o,
   input  logic            chatter_clr_i
);

   if (ON_TH == '0 || OFF_TH == '0) begin : g_bad_th
      $error("io_debounce_bank: ON_TH and OFF_TH must be in %0d..%0d", TH_MIN, TH_MAX);
   end
   if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_nch
      $error("io_debounce_bank: N_CH must be in %0d..%0d", N_CH_MIN, N_CH_MAX);
   end

   logic [N_CH-1:0] w_chatter_clr;
   ch_out_t         w_ch [N_CH];

   assign w_chatter_clr = {N_CH{chatter_clr_i}};

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      io_debounce_ch #(
         .ON_TH    (ON_TH),
         .OFF_TH   (OFF_TH),
         .RST_LVL  (RST_LVL),
         .CHAT_LIM (CHAT_LIM)
      ) u_ch (
         .i_clk         (clk),
         .i_rst         (rst),
         .i_in          (in_i[gi]),
         .i_chatter_clr (w_chatter_clr[gi]),
         .o_ch          (w_ch[gi])
      );

      assign lvl_o[gi]     = w_ch[gi].lvl;
      assign rise_o[gi]    = w_ch[gi].rise;
      assign fall_o[gi]    = w_ch[gi].fall;
      assign chatter_o[gi] = w_ch[gi].chatter;
   end

endmodule
